// File: rtl/dbus_responder_pkg.sv
// Shared data-bus types and responder constants.
package dbus_responder_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [63:0] DBUS_BASE = 64'h8000_0000;

endpackage

// File: rtl/dbus_responder_if.sv
// Data-bus request/response bundle between memory stage and responder.
interface dbus_responder_if;

    dbus_responder_pkg::dbus_req_t  dreq;
    dbus_responder_pkg::dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_responder_ram.sv
// Single-port DEPTH x 64 RAM, byte-enable write, combinational read.
module dbus_ram #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [7:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [63:0]   i_wdata,
    output logic [63:0]   o_rdata
);

    logic [63:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder: word RAM behind a fixed-latency IDLE/WAIT/RESP handshake.
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned LATENCY = 2,
    parameter logic [63:0] BASE    = DBUS_BASE
) (
    input  logic             clk,
    input  logic             reset,
    dbus_responder_if.slave  bus,
    output logic [15:0]      oor_cnt,
    output logic             busy
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;
    localparam logic [3:0]  LAT  = 4'(LATENCY);

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic          r_in_range;
    logic [7:0]    r_strobe;
    logic [63:0]   r_wdata;
    dbus_resp_t    r_dresp;
    logic [15:0]   r_oor_cnt;

    logic [63:0]   w_off;
    logic          w_in_range;
    logic [63:0]   w_rdata;
    logic          w_we;
    logic          w_unused;

    assign w_off      = bus.dreq.addr - BASE;
    assign w_in_range = (bus.dreq.addr >= BASE) && (w_off < SPAN);
    assign w_unused   = ^bus.dreq.size;

    // Gated by reset so a write caught by reset in RESP is never committed.
    assign w_we = (r_state == ST_RESP) && r_in_range && (r_strobe != 8'h00) && reset;

    dbus_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_be    (r_strobe),
        .i_addr  (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_dresp   <= '0;
            r_oor_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_dresp <= '0;
                    if (bus.dreq.valid) begin
                        r_idx      <= w_off[AW+2:3];
                        r_in_range <= w_in_range;
                        r_strobe   <= bus.dreq.strobe;
                        r_wdata    <= bus.dreq.data;
                        r_cnt      <= LAT;
                        r_state    <= (LATENCY > 0) ? ST_WAIT : ST_RESP;
                    end
                end
                ST_WAIT: begin
                    r_dresp <= '0;
                    r_cnt   <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_dresp.addr_ok <= 1'b1;
                    r_dresp.data_ok <= 1'b1;
                    r_dresp.data    <= (r_in_range && (r_strobe == 8'h00)) ? w_rdata : '0;
                    if (!r_in_range && (r_oor_cnt != 16'hFFFF)) begin
                        r_oor_cnt <= r_oor_cnt + 16'd1;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_dresp <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dresp = r_dresp;
    assign oor_cnt   = r_oor_cnt;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dbus_responder.sv
// Directed + random bench for dbus_responder at LATENCY 2 and LATENCY 0.
module tb_dbus_responder;
    import dbus_responder_pkg::*;

    localparam int unsigned DEPTH = 4096;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst_l2 = 1'b0;
    logic rst_l0 = 1'b0;
    logic [15:0] oor_l2, oor_l0;
    logic busy_l2, busy_l0;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: word contents of the low 16 words, and out-of-range counts.
    logic [63:0] mdl [2][16];
    int          mdl_oor [2];

    dbus_responder_if if_l2 ();
    dbus_responder_if if_l0 ();

    dbus_responder #(.DEPTH(DEPTH), .LATENCY(2), .BASE(BASE)) u_l2 (
        .clk(clk), .reset(rst_l2), .bus(if_l2.slave), .oor_cnt(oor_l2), .busy(busy_l2)
    );

    dbus_responder #(.DEPTH(DEPTH), .LATENCY(0), .BASE(BASE)) u_l0 (
        .clk(clk), .reset(rst_l0), .bus(if_l0.slave), .oor_cnt(oor_l0), .busy(busy_l0)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [63:0] a,
                         input logic [7:0] s, input logic [63:0] d);
        dbus_req_t r;
        r.valid = v; r.addr = a; r.size = MSIZE8; r.strobe = s; r.data = d;
        if (sel == 0) if_l2.dreq = r;
        else          if_l0.dreq = r;
    endtask

    function automatic dbus_resp_t resp_of(input int sel);
        return (sel == 0) ? if_l2.dresp : if_l0.dresp;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy_l2 : busy_l0;
    endfunction

    function automatic logic [15:0] oor_of(input int sel);
        return (sel == 0) ? oor_l2 : oor_l0;
    endfunction

    function automatic bit in_range(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'(DEPTH) * 64'd8);
    endfunction

    // One complete transaction from IDLE; call #1 after a rising edge.
    task automatic xact(input int sel, input logic [63:0] a, input logic [7:0] s,
                        input logic [63:0] d, input string tag);
        int lat = (sel == 0) ? 2 : 0;
        int idx;
        int edges = 0;
        int busy_cycles;
        bit done = 0;
        logic [63:0] exp;
        dbus_resp_t r;
        idx = in_range(a) ? int'((a - BASE) >> 3) : 0;
        exp = (in_range(a) && s == 8'h00) ? mdl[sel][idx] : 64'h0;
        drive(sel, 1'b1, a, s, d);
        @(posedge clk); #1;
        busy_cycles = int'(busy_of(sel));
        while (!done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            r = resp_of(sel);
            if (r.data_ok) done = 1;
            else busy_cycles += int'(busy_of(sel));
        end
        drive(sel, 1'b0, '0, '0, '0);
        r = resp_of(sel);
        chk({tag, "_latency"}, 64'(edges), 64'(lat + 1));
        chk({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(lat + 1));
        chk({tag, "_addr_ok"}, 64'(r.addr_ok), 64'd1);
        chk({tag, "_data"}, r.data, exp);
        chk({tag, "_busy_at_resp"}, 64'(busy_of(sel)), 64'd0);
        if (in_range(a)) begin
            for (int i = 0; i < 8; i++)
                if (s[i]) mdl[sel][idx][8*i +: 8] = d[8*i +: 8];
        end else if (mdl_oor[sel] < 65535) begin
            mdl_oor[sel]++;
        end
        @(posedge clk); #1;
        r = resp_of(sel);
        chk({tag, "_resp_one_cycle"}, {62'd0, r.addr_ok, r.data_ok}, 64'd0);
        chk({tag, "_oor_cnt"}, 64'(oor_of(sel)), 64'(mdl_oor[sel]));
    endtask

    initial begin
        dbus_resp_t r;
        logic [63:0] a;
        logic [7:0]  s;
        int          sel;
        int          seen;

        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        mdl_oor[0] = 0;
        mdl_oor[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            r = resp_of(k);
            chk("reset_dresp", {62'd0, r.addr_ok, r.data_ok} | r.data, 64'd0);
            chk("reset_busy", 64'(busy_of(k)), 64'd0);
            chk("reset_oor", 64'(oor_of(k)), 64'd0);
        end
        rst_l2 = 1'b1;
        rst_l0 = 1'b1;
        @(posedge clk); #1;

        // Known contents for the low 16 words of both RAMs.
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 16; w++)
                xact(k, BASE + 64'(w * 8), 8'hFF, {$urandom, $urandom}, "preload");

        // Read latency with a known word.
        xact(0, 64'h8000_0010, 8'hFF, 64'hDEAD_BEEF_0123_4567, "wr_word2");
        xact(0, 64'h8000_0010, 8'h00, '0, "rd_word2");

        // Partial-lane write merge.
        xact(0, 64'h8000_0008, 8'hFF, 64'hAAAA_BBBB_CCCC_DDDD, "wr_word1_full");
        xact(0, 64'h8000_0008, 8'h0F, 64'h1111_2222_3333_4444, "wr_word1_low");
        xact(0, 64'h8000_000D, 8'h00, '0, "rd_word1_merge");

        // Out-of-range on both sides; word 0 must stay intact.
        xact(0, 64'h8000_0000, 8'hFF, 64'h0F0F_0F0F_5A5A_5A5A, "wr_word0");
        xact(0, 64'h7FFF_FFF8, 8'h00, '0, "rd_below_base");
        xact(0, 64'h8000_8000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, "wr_past_end");
        chk("oor_after_two", 64'(oor_l2), 64'd2);
        xact(0, 64'h8000_0000, 8'h00, '0, "rd_word0_intact");

        // Back-to-back held-valid reads at zero latency.
        drive(1, 1'b1, BASE, 8'h00, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        r = resp_of(1);
        chk("b2b_first_data_ok", 64'(r.data_ok), 64'd1);
        chk("b2b_first_data", r.data, mdl[1][0]);
        drive(1, 1'b1, BASE + 64'd8, 8'h00, '0);
        @(posedge clk); #1;
        r = resp_of(1);
        chk("b2b_gap_data_ok", 64'(r.data_ok), 64'd0);
        @(posedge clk); #1;
        r = resp_of(1);
        chk("b2b_second_data_ok", 64'(r.data_ok), 64'd1);
        chk("b2b_second_data", r.data, mdl[1][1]);
        drive(1, 1'b0, '0, '0, '0);
        @(posedge clk); #1;

        // Reset in WAIT aborts a pending write.
        drive(0, 1'b1, 64'h8000_0010, 8'hFF, 64'h0BAD_0BAD_0BAD_0BAD);
        @(posedge clk); #1;
        rst_l2 = 1'b0;
        @(posedge clk); #1;
        r = resp_of(0);
        chk("abort_dresp", {62'd0, r.addr_ok, r.data_ok} | r.data, 64'd0);
        chk("abort_busy", 64'(busy_l2), 64'd0);
        drive(0, 1'b0, '0, '0, '0);
        seen = 0;
        @(posedge clk); #1;
        rst_l2 = 1'b1;
        mdl_oor[0] = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            r = resp_of(0);
            seen += int'(r.data_ok);
        end
        chk("abort_no_data_ok", 64'(seen), 64'd0);
        xact(0, 64'h8000_0010, 8'h00, '0, "rd_after_abort");

        // Randomized traffic on both instances.
        for (int i = 0; i < 40; i++) begin
            sel = i % 2;
            case ($urandom_range(0, 9))
                0:       a = BASE - 64'(8 * $urandom_range(1, 4)) + 64'($urandom_range(0, 7));
                1:       a = BASE + 64'(DEPTH) * 64'd8 + 64'(8 * $urandom_range(0, 100));
                default: a = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
            endcase
            s = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            xact(sel, a, s, {$urandom, $urandom}, "random");
        end

        // Saturation of the out-of-range counter.
        force u_l2.r_oor_cnt = 16'hFFFD;
        #1;
        release u_l2.r_oor_cnt;
        #1;
        mdl_oor[0] = 65533;
        chk("oor_preset", 64'(oor_l2), 64'(mdl_oor[0]));
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++)
            xact(0, 64'h7FFF_0000, 8'h00, '0, "oor_sat");
        chk("oor_saturated", 64'(oor_l2), 64'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
